// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the IF/ID/EX hazard controller.
// Provides register-file geometry, the controller FSM encoding and a helper
// that tests whether a source register is blocked by a pending load.
package hazard_ctrl_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_NUM    = 32;
    localparam int unsigned CNT_W      = 3;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

    typedef enum logic [1:0] {
        CTRL_RUN   = 2'd0,
        CTRL_STALL = 2'd1,
        CTRL_FLUSH = 2'd2
    } ctrl_state_e;

    // x0 never carries a pending load, whatever the vector holds.
    function automatic logic reg_pending(input logic [REG_NUM-1:0]    busy,
                                         input logic [REG_ADDR_W-1:0] addr);
        return busy[addr] && (addr != ZERO_REG);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle.
// master: pipeline side (drives decode/EX/MEM status, receives control).
// slave : controller side (receives status, drives hold/bubble/flush/redirect
//         and the scoreboard view).
interface hazard_ctrl_if;
    import hazard_ctrl_pkg::*;

    logic                  id_instr_valid_in;
    logic [REG_ADDR_W-1:0] id_reg1_addr_in;
    logic [REG_ADDR_W-1:0] id_reg2_addr_in;
    logic                  id_wen_in;
    logic [REG_ADDR_W-1:0] id_write_addr_in;
    logic                  id_is_load_in;
    logic                  ex_jump_flag_in;
    logic [31:0]           ex_jump_addr_in;
    logic                  mem_load_done_in;
    logic [REG_ADDR_W-1:0] mem_load_rd_in;

    logic                  ctrl_hold_out;
    logic                  ctrl_bubble_out;
    logic                  ctrl_flush_out;
    logic                  ctrl_jump_flag_out;
    logic [31:0]           ctrl_jump_addr_out;
    logic [REG_NUM-1:0]    ctrl_busy_vec_out;
    logic [CNT_W-1:0]      ctrl_outstanding_out;

    modport master (
        output id_instr_valid_in, id_reg1_addr_in, id_reg2_addr_in, id_wen_in,
               id_write_addr_in, id_is_load_in, ex_jump_flag_in, ex_jump_addr_in,
               mem_load_done_in, mem_load_rd_in,
        input  ctrl_hold_out, ctrl_bubble_out, ctrl_flush_out, ctrl_jump_flag_out,
               ctrl_jump_addr_out, ctrl_busy_vec_out, ctrl_outstanding_out
    );

    modport slave (
        input  id_instr_valid_in, id_reg1_addr_in, id_reg2_addr_in, id_wen_in,
               id_write_addr_in, id_is_load_in, ex_jump_flag_in, ex_jump_addr_in,
               mem_load_done_in, mem_load_rd_in,
        output ctrl_hold_out, ctrl_bubble_out, ctrl_flush_out, ctrl_jump_flag_out,
               ctrl_jump_addr_out, ctrl_busy_vec_out, ctrl_outstanding_out
    );

endinterface

// File: rtl/hazard_ctrl_load_scoreboard.sv
// Load scoreboard: one busy bit per architectural register plus a count of
// loads in flight.
//   clk, rst  : core clock, synchronous active-high reset
//   set_en    : mark set_addr busy at the next edge (a load issues)
//   clr_en    : clear clr_addr at the next edge (a load writeback completes)
//   busy_vec  : registered busy bits, bit 0 always 0
//   count     : registered number of in-flight loads
module load_scoreboard
    import hazard_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_en,
    input  logic [REG_ADDR_W-1:0] set_addr,
    input  logic                  clr_en,
    input  logic [REG_ADDR_W-1:0] clr_addr,
    output logic [REG_NUM-1:0]    busy_vec,
    output logic [CNT_W-1:0]      count
);

    logic [REG_NUM-1:0] busy_q, busy_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               clr_eff;

    // A completion with nothing in flight is spurious and dropped entirely.
    assign clr_eff = clr_en && (count_q != '0);

    always_comb begin
        busy_d = busy_q;
        if (clr_eff) busy_d[clr_addr] = 1'b0;
        // Set after clear so a same-register issue/complete keeps the bit.
        if (set_en)  busy_d[set_addr] = 1'b1;
        busy_d[0] = 1'b0;

        count_d = count_q;
        if (set_en && !clr_eff)      count_d = count_q + 3'd1;
        else if (!set_en && clr_eff) count_d = count_q - 3'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    assign busy_vec = busy_q;
    assign count    = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Front-end pipeline sequencing controller.
// Stalls decode on load-use and load-capacity hazards, and sequences a
// FLUSH_CYCLES-long flush (counted from the jump cycle) when EX redirects.
//   clk, rst : core clock, synchronous active-high reset
//   bus      : hazard_ctrl_if slave -- decode/EX/MEM status in, hold, bubble,
//              flush, PC redirect and scoreboard view out
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned FLUSH_CYCLES    = 2
) (
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] MAX_CNT      = CNT_W'(MAX_OUTSTANDING);
    localparam logic [2:0]       FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

    ctrl_state_e        state_q, state_d;
    logic [2:0]         flush_cnt_q, flush_cnt_d;
    logic [REG_NUM-1:0] busy_vec;
    logic [CNT_W-1:0]   outstanding;
    logic               haz, cap, stall_req, issue;

    assign haz = bus.id_instr_valid_in &&
                 (reg_pending(busy_vec, bus.id_reg1_addr_in) ||
                  reg_pending(busy_vec, bus.id_reg2_addr_in));
    assign cap = bus.id_instr_valid_in && bus.id_is_load_in && (outstanding == MAX_CNT);
    assign stall_req = haz || cap;

    assign issue = bus.id_instr_valid_in && bus.id_is_load_in && bus.id_wen_in &&
                   (bus.id_write_addr_in != ZERO_REG) && !stall_req &&
                   (state_q != CTRL_FLUSH) && !bus.ex_jump_flag_in;

    load_scoreboard u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_en   (issue),
        .set_addr (bus.id_write_addr_in),
        .clr_en   (bus.mem_load_done_in),
        .clr_addr (bus.mem_load_rd_in),
        .busy_vec (busy_vec),
        .count    (outstanding)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= CTRL_RUN;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // The jump cycle itself is the first flush cycle, so FLUSH holds for
    // FLUSH_CYCLES-1 further cycles; with FLUSH_CYCLES=1 it is skipped.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            CTRL_RUN, CTRL_STALL: begin
                if (bus.ex_jump_flag_in) begin
                    state_d     = (FLUSH_RELOAD != 3'd0) ? CTRL_FLUSH : CTRL_RUN;
                    flush_cnt_d = FLUSH_RELOAD;
                end else if (stall_req) begin
                    state_d = CTRL_STALL;
                end else begin
                    state_d = CTRL_RUN;
                end
            end
            CTRL_FLUSH: begin
                if (bus.ex_jump_flag_in) begin
                    state_d     = (FLUSH_RELOAD != 3'd0) ? CTRL_FLUSH : CTRL_RUN;
                    flush_cnt_d = FLUSH_RELOAD;
                end else if (flush_cnt_q <= 3'd1) begin
                    state_d     = CTRL_RUN;
                    flush_cnt_d = '0;
                end else begin
                    flush_cnt_d = flush_cnt_q - 3'd1;
                end
            end
            default: begin
                state_d     = CTRL_RUN;
                flush_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        bus.ctrl_jump_flag_out   = bus.ex_jump_flag_in;
        bus.ctrl_jump_addr_out   = bus.ex_jump_flag_in ? bus.ex_jump_addr_in : 32'h0;
        bus.ctrl_flush_out       = bus.ex_jump_flag_in || (state_q == CTRL_FLUSH);
        bus.ctrl_hold_out        = stall_req && !bus.ctrl_flush_out;
        bus.ctrl_bubble_out      = stall_req && !bus.ctrl_flush_out;
        bus.ctrl_busy_vec_out    = busy_vec;
        bus.ctrl_outstanding_out = outstanding;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl (MAX_OUTSTANDING=2, FLUSH_CYCLES=2):
// directed scenarios followed by randomized traffic against a reference model.
module tb_hazard_ctrl;

    localparam int MAX = 2;
    localparam int FC  = 2;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;

    hazard_ctrl_if bus ();

    hazard_ctrl #(
        .MAX_OUTSTANDING (MAX),
        .FLUSH_CYCLES    (FC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic idle();
        bus.id_instr_valid_in = 1'b0;
        bus.id_reg1_addr_in   = 5'd0;
        bus.id_reg2_addr_in   = 5'd0;
        bus.id_wen_in         = 1'b0;
        bus.id_write_addr_in  = 5'd0;
        bus.id_is_load_in     = 1'b0;
        bus.ex_jump_flag_in   = 1'b0;
        bus.ex_jump_addr_in   = 32'h0;
        bus.mem_load_done_in  = 1'b0;
        bus.mem_load_rd_in    = 5'd0;
    endtask

    // Inputs change 1 time unit after a rising edge; outputs sampled 1 later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_load(input logic [4:0] rd);
        idle();
        bus.id_instr_valid_in = 1'b1;
        bus.id_is_load_in     = 1'b1;
        bus.id_wen_in         = 1'b1;
        bus.id_write_addr_in  = rd;
    endtask

    task automatic drive_done(input logic [4:0] rd);
        idle();
        bus.mem_load_done_in = 1'b1;
        bus.mem_load_rd_in   = rd;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        n_checks++; if (bus.ctrl_flush_out !== 1'b0) $display("FAIL reset_flush: got %b want 0", bus.ctrl_flush_out); else n_pass++;
        n_checks++; if (bus.ctrl_hold_out !== 1'b0) $display("FAIL reset_hold: got %b want 0", bus.ctrl_hold_out); else n_pass++;
        n_checks++; if (bus.ctrl_busy_vec_out !== 32'h0) $display("FAIL reset_busy: got %h want 0", bus.ctrl_busy_vec_out); else n_pass++;
        n_checks++; if (bus.ctrl_outstanding_out !== 3'd0) $display("FAIL reset_outstanding: got %0d want 0", bus.ctrl_outstanding_out); else n_pass++;
        n_checks++; if (bus.ctrl_jump_addr_out !== 32'h0) $display("FAIL reset_jaddr: got %h want 0", bus.ctrl_jump_addr_out); else n_pass++;
        step();
    endtask

    task automatic test_reset_mid_flush();
        drive_load(5'd12);
        step();
        idle();
        bus.ex_jump_flag_in = 1'b1;
        bus.ex_jump_addr_in = 32'h100;
        #1;
        n_checks++; if (bus.ctrl_flush_out !== 1'b1) $display("FAIL rmf_jump_flush: got %b want 1", bus.ctrl_flush_out); else n_pass++;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle();
        #1;
        n_checks++; if (bus.ctrl_flush_out !== 1'b0) $display("FAIL rmf_flush: got %b want 0", bus.ctrl_flush_out); else n_pass++;
        n_checks++; if (bus.ctrl_busy_vec_out !== 32'h0) $display("FAIL rmf_busy: got %h want 0", bus.ctrl_busy_vec_out); else n_pass++;
        n_checks++; if (bus.ctrl_outstanding_out !== 3'd0) $display("FAIL rmf_outstanding: got %0d want 0", bus.ctrl_outstanding_out); else n_pass++;
        step();
    endtask

    task automatic test_load_use();
        drive_load(5'd5);
        #1;
        n_checks++; if (bus.ctrl_hold_out !== 1'b0) $display("FAIL lu_t0_hold: got %b want 0", bus.ctrl_hold_out); else n_pass++;
        step();
        idle();
        bus.id_instr_valid_in = 1'b1;
        bus.id_reg1_addr_in   = 5'd5;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++; if (bus.ctrl_hold_out !== 1'b1) $display("FAIL lu_hold c%0d: got %b want 1", i, bus.ctrl_hold_out); else n_pass++;
            n_checks++; if (bus.ctrl_bubble_out !== 1'b1) $display("FAIL lu_bubble c%0d: got %b want 1", i, bus.ctrl_bubble_out); else n_pass++;
            step();
        end
        n_checks++; if (bus.ctrl_busy_vec_out !== 32'h20) $display("FAIL lu_busy: got %h want 00000020", bus.ctrl_busy_vec_out); else n_pass++;
        bus.mem_load_done_in = 1'b1;
        bus.mem_load_rd_in   = 5'd5;
        #1;
        n_checks++; if (bus.ctrl_hold_out !== 1'b1) $display("FAIL lu_no_bypass: got %b want 1", bus.ctrl_hold_out); else n_pass++;
        step();
        bus.mem_load_done_in = 1'b0;
        #1;
        n_checks++; if (bus.ctrl_hold_out !== 1'b0) $display("FAIL lu_release: got %b want 0", bus.ctrl_hold_out); else n_pass++;
        n_checks++; if (bus.ctrl_busy_vec_out !== 32'h0) $display("FAIL lu_busy_clr: got %h want 0", bus.ctrl_busy_vec_out); else n_pass++;
        idle();
        step();
    endtask

    task automatic test_x0();
        drive_load(5'd0);
        step();
        idle();
        bus.id_instr_valid_in = 1'b1;
        #1;
        n_checks++; if (bus.ctrl_hold_out !== 1'b0) $display("FAIL x0_hold: got %b want 0", bus.ctrl_hold_out); else n_pass++;
        n_checks++; if (bus.ctrl_busy_vec_out !== 32'h0) $display("FAIL x0_busy: got %h want 0", bus.ctrl_busy_vec_out); else n_pass++;
        n_checks++; if (bus.ctrl_outstanding_out !== 3'd0) $display("FAIL x0_outstanding: got %0d want 0", bus.ctrl_outstanding_out); else n_pass++;
        idle();
        step();
    endtask

    task automatic test_capacity();
        drive_load(5'd3);
        step();
        drive_load(5'd4);
        #1;
        n_checks++; if (bus.ctrl_hold_out !== 1'b0) $display("FAIL cap_second_hold: got %b want 0", bus.ctrl_hold_out); else n_pass++;
        step();
        drive_load(5'd6);
        #1;
        n_checks++; if (bus.ctrl_hold_out !== 1'b1) $display("FAIL cap_full_hold: got %b want 1", bus.ctrl_hold_out); else n_pass++;
        n_checks++; if (bus.ctrl_outstanding_out !== 3'd2) $display("FAIL cap_count: got %0d want 2", bus.ctrl_outstanding_out); else n_pass++;
        step();
        bus.mem_load_done_in = 1'b1;
        bus.mem_load_rd_in   = 5'd3;
        #1;
        n_checks++; if (bus.ctrl_hold_out !== 1'b1) $display("FAIL cap_done_cycle_hold: got %b want 1", bus.ctrl_hold_out); else n_pass++;
        step();
        bus.mem_load_done_in = 1'b0;
        #1;
        n_checks++; if (bus.ctrl_hold_out !== 1'b0) $display("FAIL cap_release: got %b want 0", bus.ctrl_hold_out); else n_pass++;
        n_checks++; if (bus.ctrl_outstanding_out !== 3'd1) $display("FAIL cap_after_done: got %0d want 1", bus.ctrl_outstanding_out); else n_pass++;
        step();
        n_checks++; if (bus.ctrl_outstanding_out !== 3'd2) $display("FAIL cap_refill: got %0d want 2", bus.ctrl_outstanding_out); else n_pass++;
        n_checks++; if (bus.ctrl_busy_vec_out !== 32'h50) $display("FAIL cap_busy: got %h want 00000050", bus.ctrl_busy_vec_out); else n_pass++;
        drive_done(5'd4);
        step();
        drive_done(5'd6);
        step();
        idle();
        #1;
        n_checks++; if (bus.ctrl_outstanding_out !== 3'd0) $display("FAIL cap_drain: got %0d want 0", bus.ctrl_outstanding_out); else n_pass++;
        step();
    endtask

    task automatic test_collision();
        drive_load(5'd7);
        step();
        drive_load(5'd7);
        bus.mem_load_done_in = 1'b1;
        bus.mem_load_rd_in   = 5'd7;
        step();
        idle();
        #1;
        n_checks++; if (bus.ctrl_busy_vec_out !== 32'h80) $display("FAIL coll_busy: got %h want 00000080", bus.ctrl_busy_vec_out); else n_pass++;
        n_checks++; if (bus.ctrl_outstanding_out !== 3'd1) $display("FAIL coll_count: got %0d want 1", bus.ctrl_outstanding_out); else n_pass++;
        drive_done(5'd7);
        step();
        idle();
        // Spurious completion at zero must not underflow.
        drive_done(5'd9);
        step();
        idle();
        #1;
        n_checks++; if (bus.ctrl_outstanding_out !== 3'd0) $display("FAIL underflow: got %0d want 0", bus.ctrl_outstanding_out); else n_pass++;
        step();
    endtask

    task automatic test_jump_over_stall();
        drive_load(5'd9);
        step();
        idle();
        bus.id_instr_valid_in = 1'b1;
        bus.id_reg2_addr_in   = 5'd9;
        bus.ex_jump_addr_in   = 32'hdead_beef;
        #1;
        n_checks++; if (bus.ctrl_hold_out !== 1'b1) $display("FAIL js_stall: got %b want 1", bus.ctrl_hold_out); else n_pass++;
        n_checks++; if (bus.ctrl_jump_addr_out !== 32'h0) $display("FAIL js_addr_idle: got %h want 0", bus.ctrl_jump_addr_out); else n_pass++;
        step();
        bus.ex_jump_flag_in = 1'b1;
        bus.ex_jump_addr_in = 32'h0000_0040;
        #1;
        n_checks++; if (bus.ctrl_jump_flag_out !== 1'b1) $display("FAIL js_jflag: got %b want 1", bus.ctrl_jump_flag_out); else n_pass++;
        n_checks++; if (bus.ctrl_jump_addr_out !== 32'h40) $display("FAIL js_jaddr: got %h want 00000040", bus.ctrl_jump_addr_out); else n_pass++;
        n_checks++; if (bus.ctrl_flush_out !== 1'b1) $display("FAIL js_flush0: got %b want 1", bus.ctrl_flush_out); else n_pass++;
        n_checks++; if (bus.ctrl_hold_out !== 1'b0) $display("FAIL js_hold_suppr: got %b want 0", bus.ctrl_hold_out); else n_pass++;
        step();
        bus.ex_jump_flag_in = 1'b0;
        #1;
        n_checks++; if (bus.ctrl_flush_out !== 1'b1) $display("FAIL js_flush1: got %b want 1", bus.ctrl_flush_out); else n_pass++;
        n_checks++; if (bus.ctrl_bubble_out !== 1'b0) $display("FAIL js_bubble_suppr: got %b want 0", bus.ctrl_bubble_out); else n_pass++;
        step();
        n_checks++; if (bus.ctrl_flush_out !== 1'b0) $display("FAIL js_flush_end: got %b want 0", bus.ctrl_flush_out); else n_pass++;
        n_checks++; if (bus.ctrl_hold_out !== 1'b1) $display("FAIL js_stall_again: got %b want 1", bus.ctrl_hold_out); else n_pass++;
        // Re-jump inside the flush window extends it by one cycle.
        bus.ex_jump_flag_in = 1'b1;
        step();
        #1;
        n_checks++; if (bus.ctrl_flush_out !== 1'b1) $display("FAIL js_rejump_flush: got %b want 1", bus.ctrl_flush_out); else n_pass++;
        step();
        bus.ex_jump_flag_in = 1'b0;
        #1;
        n_checks++; if (bus.ctrl_flush_out !== 1'b1) $display("FAIL js_extend: got %b want 1", bus.ctrl_flush_out); else n_pass++;
        step();
        n_checks++; if (bus.ctrl_flush_out !== 1'b0) $display("FAIL js_extend_end: got %b want 0", bus.ctrl_flush_out); else n_pass++;
        idle();
        drive_done(5'd9);
        step();
        idle();
        step();
    endtask

    task automatic test_random();
        bit          m_busy [32];
        int          m_out;
        int          m_left;
        logic        haz, cap, iss, done_eff;
        logic        e_flush, e_hold;
        logic [31:0] e_busy, e_addr;
        int          start;

        rst = 1'b1;
        idle();
        step();
        rst = 1'b0;
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        m_out  = 0;
        m_left = 0;

        for (int cyc = 0; cyc < 600; cyc++) begin
            idle();
            rst = ($urandom_range(0, 99) == 0);
            bus.id_instr_valid_in = ($urandom_range(0, 9) < 7);
            bus.id_reg1_addr_in   = 5'($urandom_range(0, 7));
            bus.id_reg2_addr_in   = 5'($urandom_range(0, 7));
            bus.id_is_load_in     = ($urandom_range(0, 9) < 5);
            bus.id_wen_in         = ($urandom_range(0, 9) < 8);
            bus.id_write_addr_in  = 5'($urandom_range(0, 7));
            bus.ex_jump_flag_in   = ($urandom_range(0, 99) < 8);
            bus.ex_jump_addr_in   = $urandom;
            if ($urandom_range(0, 9) < 3) begin
                bus.mem_load_done_in = 1'b1;
                bus.mem_load_rd_in   = 5'($urandom_range(0, 7));
                start = $urandom_range(0, 31);
                for (int k = 0; k < 32; k++) begin
                    if (m_busy[(start + k) % 32]) begin
                        bus.mem_load_rd_in = 5'((start + k) % 32);
                        break;
                    end
                end
            end
            #1;

            haz = bus.id_instr_valid_in &&
                  ((bus.id_reg1_addr_in != 0 && m_busy[bus.id_reg1_addr_in]) ||
                   (bus.id_reg2_addr_in != 0 && m_busy[bus.id_reg2_addr_in]));
            cap = bus.id_instr_valid_in && bus.id_is_load_in && (m_out == MAX);
            e_flush = bus.ex_jump_flag_in || (m_left > 0);
            e_hold  = (haz || cap) && !e_flush;
            e_addr  = bus.ex_jump_flag_in ? bus.ex_jump_addr_in : 32'h0;
            for (int i = 0; i < 32; i++) e_busy[i] = m_busy[i];

            n_checks++; if (bus.ctrl_flush_out !== e_flush) $display("FAIL rnd_flush c%0d: got %b want %b", cyc, bus.ctrl_flush_out, e_flush); else n_pass++;
            n_checks++; if (bus.ctrl_hold_out !== e_hold) $display("FAIL rnd_hold c%0d: got %b want %b", cyc, bus.ctrl_hold_out, e_hold); else n_pass++;
            n_checks++; if (bus.ctrl_bubble_out !== e_hold) $display("FAIL rnd_bubble c%0d: got %b want %b", cyc, bus.ctrl_bubble_out, e_hold); else n_pass++;
            n_checks++; if (bus.ctrl_jump_flag_out !== bus.ex_jump_flag_in) $display("FAIL rnd_jflag c%0d: got %b want %b", cyc, bus.ctrl_jump_flag_out, bus.ex_jump_flag_in); else n_pass++;
            n_checks++; if (bus.ctrl_jump_addr_out !== e_addr) $display("FAIL rnd_jaddr c%0d: got %h want %h", cyc, bus.ctrl_jump_addr_out, e_addr); else n_pass++;
            n_checks++; if (bus.ctrl_busy_vec_out !== e_busy) $display("FAIL rnd_busy c%0d: got %h want %h", cyc, bus.ctrl_busy_vec_out, e_busy); else n_pass++;
            n_checks++; if (int'(bus.ctrl_outstanding_out) != m_out) $display("FAIL rnd_outstanding c%0d: got %0d want %0d", cyc, bus.ctrl_outstanding_out, m_out); else n_pass++;

            // Model advance for the coming edge.
            if (rst) begin
                foreach (m_busy[i]) m_busy[i] = 1'b0;
                m_out  = 0;
                m_left = 0;
            end else begin
                iss = bus.id_instr_valid_in && bus.id_is_load_in && bus.id_wen_in &&
                      (bus.id_write_addr_in != 0) && !haz && !cap && (m_left == 0) &&
                      !bus.ex_jump_flag_in;
                done_eff = bus.mem_load_done_in && (m_out != 0);
                if (done_eff) m_busy[bus.mem_load_rd_in] = 1'b0;
                if (iss) m_busy[bus.id_write_addr_in] = 1'b1;
                m_out = m_out + (iss ? 1 : 0) - (done_eff ? 1 : 0);
                if (bus.ex_jump_flag_in) m_left = FC - 1;
                else if (m_left > 0)     m_left = m_left - 1;
            end
            step();
        end
        rst = 1'b0;
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_reset_mid_flush();
        test_load_use();
        test_x0();
        test_capacity();
        test_collision();
        test_jump_over_stall();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
